// File: rtl/bus_interconnect_if.sv
// Host and device request/response bundle for bus_interconnect.
// slave is the interconnect's view; master is the view of the surrounding hosts, devices and config.
interface bus_interconnect_if #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  logic [NrHosts-1:0]                   host_req_i;
  logic [NrHosts-1:0]                   host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]                   host_we_i;
  logic [NrHosts-1:0][BeWidth-1:0]      host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]                   host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
  logic [NrHosts-1:0]                   host_err_o;

  logic [NrDevices-1:0]                   device_req_o;
  logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
  logic [NrDevices-1:0]                   device_we_o;
  logic [NrDevices-1:0][BeWidth-1:0]      device_be_o;
  logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
  logic [NrDevices-1:0]                   device_rvalid_i;
  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;
  logic [NrDevices-1:0]                   device_err_i;

  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );
endinterface

// File: rtl/bus_interconnect.sv
// Single-outstanding host->device interconnect: fixed-priority grant and address decode in the request cycle,
// response routed back the next cycle. Devices never stall; losing hosts hold their request until granted.
module bus_interconnect #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input logic clk_i,
  input logic rst_i,
  bus_interconnect_if.slave bus
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic                    gnt_any;
  logic [HostIdxW-1:0]     win_host;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeWidth-1:0]      win_be;
  logic [DataWidth-1:0]    win_wdata;
  logic                    dev_hit;
  logic [DevIdxW-1:0]      hit_dev;

  logic                rsp_valid_d, rsp_valid_q;
  logic [HostIdxW-1:0] rsp_host_d, rsp_host_q;
  logic [DevIdxW-1:0]  rsp_dev_d, rsp_dev_q;
  logic                rsp_unmapped_d, rsp_unmapped_q;

  logic                 sel_rvalid;
  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_err;

  // Descending scan so the lowest-index requester is the last (winning) assignment.
  always_comb begin
    gnt_any   = 1'b0;
    win_host  = '0;
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (bus.host_req_i[h]) begin
        gnt_any   = 1'b1;
        win_host  = HostIdxW'(h);
        win_addr  = bus.host_addr_i[h];
        win_we    = bus.host_we_i[h];
        win_be    = bus.host_be_i[h];
        win_wdata = bus.host_wdata_i[h];
      end
    end
  end

  always_comb begin
    dev_hit = 1'b0;
    hit_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & bus.cfg_device_addr_mask[d]) ==
          (bus.cfg_device_addr_base[d] & bus.cfg_device_addr_mask[d])) begin
        dev_hit = 1'b1;
        hit_dev = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    bus.host_gnt_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_gnt_o[h] = gnt_any && (win_host == HostIdxW'(h));
    end
  end

  always_comb begin
    bus.device_req_o   = '0;
    bus.device_addr_o  = '0;
    bus.device_we_o    = '0;
    bus.device_be_o    = '0;
    bus.device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      bus.device_req_o[d]   = gnt_any && dev_hit && (hit_dev == DevIdxW'(d));
      bus.device_addr_o[d]  = win_addr;
      bus.device_we_o[d]    = win_we;
      bus.device_be_o[d]    = win_be;
      bus.device_wdata_o[d] = win_wdata;
    end
  end

  always_comb begin
    rsp_valid_d    = gnt_any;
    rsp_host_d     = gnt_any ? win_host : '0;
    rsp_dev_d      = gnt_any ? hit_dev : '0;
    rsp_unmapped_d = gnt_any && !dev_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q    <= 1'b0;
      rsp_host_q     <= '0;
      rsp_dev_q      <= '0;
      rsp_unmapped_q <= 1'b0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_host_q     <= rsp_host_d;
      rsp_dev_q      <= rsp_dev_d;
      rsp_unmapped_q <= rsp_unmapped_d;
    end
  end

  // An unmapped request is answered by the interconnect itself with an error.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    sel_err    = 1'b0;
    if (rsp_unmapped_q) begin
      sel_rvalid = 1'b1;
      sel_err    = 1'b1;
    end else begin
      for (int d = 0; d < NrDevices; d++) begin
        if (rsp_dev_q == DevIdxW'(d)) begin
          sel_rvalid = bus.device_rvalid_i[d];
          sel_rdata  = bus.device_rdata_i[d];
          sel_err    = bus.device_err_i[d];
        end
      end
    end
  end

  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_rdata_o  = '0;
    bus.host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (rsp_valid_q && (rsp_host_q == HostIdxW'(h))) begin
        bus.host_rvalid_o[h] = sel_rvalid;
        bus.host_rdata_o[h]  = sel_rdata;
        bus.host_err_o[h]    = sel_err;
      end
    end
  end
endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk;
  logic rst;

  bus_interconnect_if #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bus_if ();

  bus_interconnect #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] cfg_base [ND];
  logic [AW-1:0] cfg_mask [ND];

  // Reference model: one remembered outstanding request (host, device or -1 when unmapped).
  int m_valid = 0;
  int m_host  = 0;
  int m_dev   = 0;

  logic [NH-1:0]         e_gnt;
  logic [ND-1:0]         e_dreq;
  logic [NH-1:0]         e_rvalid;
  logic [NH-1:0]         e_err;
  logic [NH-1:0][DW-1:0] e_rdata;
  int                    e_win;

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++) begin
      if ((a & cfg_mask[d]) == (cfg_base[d] & cfg_mask[d])) return d;
    end
    return -1;
  endfunction

  function automatic int winner(input logic [NH-1:0] r);
    for (int h = 0; h < NH; h++) begin
      if (r[h]) return h;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus_if.host_req_i      = '0;
    bus_if.host_addr_i     = '0;
    bus_if.host_we_i       = '0;
    bus_if.host_be_i       = '0;
    bus_if.host_wdata_i    = '0;
    bus_if.device_rvalid_i = '0;
    bus_if.device_rdata_i  = '0;
    bus_if.device_err_i    = '0;
  endtask

  task automatic model_expect();
    int dv;
    e_gnt    = '0;
    e_dreq   = '0;
    e_rvalid = '0;
    e_err    = '0;
    e_rdata  = '0;
    e_win    = winner(bus_if.host_req_i);
    if (e_win >= 0) begin
      e_gnt[e_win] = 1'b1;
      dv = decode(bus_if.host_addr_i[e_win]);
      if (dv >= 0) e_dreq[dv] = 1'b1;
    end
    if (m_valid != 0) begin
      if (m_dev < 0) begin
        e_rvalid[m_host] = 1'b1;
        e_err[m_host]    = 1'b1;
      end else begin
        e_rvalid[m_host] = bus_if.device_rvalid_i[m_dev];
        e_rdata[m_host]  = bus_if.device_rdata_i[m_dev];
        e_err[m_host]    = bus_if.device_err_i[m_dev];
      end
    end
  endtask

  // Commit this cycle's grant into the model, then move to the next falling edge.
  task automatic advance();
    int w;
    w = winner(bus_if.host_req_i);
    if (rst || w < 0) begin
      m_valid = 0;
    end else begin
      m_valid = 1;
      m_host  = w;
      m_dev   = decode(bus_if.host_addr_i[w]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus_if.host_req_i[0]   = 1'b1;
    bus_if.host_addr_i[0]  = 32'h0010_0010;
    bus_if.device_rvalid_i = '1;
    bus_if.device_rdata_i  = {ND{32'hAAAA_5555}};
    bus_if.device_err_i    = '1;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", bus_if.host_rvalid_o);
    else n_pass++;
    n_checks++;
    if (bus_if.host_err_o !== 2'b00) $display("FAIL rst_err got=%b exp=00", bus_if.host_err_o);
    else n_pass++;
    n_checks++;
    if (bus_if.host_rdata_o !== '0) $display("FAIL rst_rdata got=%h exp=0", bus_if.host_rdata_o);
    else n_pass++;
    n_checks++;
    if (bus_if.device_req_o !== 3'b001) $display("FAIL rst_dreq got=%b exp=001", bus_if.device_req_o);
    else n_pass++;
    advance();
    clear_inputs();
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b00) $display("FAIL rst_release_rvalid got=%b exp=00", bus_if.host_rvalid_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_read();
    clear_inputs();
    bus_if.host_req_i[0]  = 1'b1;
    bus_if.host_addr_i[0] = 32'h0010_0010;
    bus_if.host_be_i[0]   = 4'hF;
    #2;
    n_checks++;
    if (bus_if.host_gnt_o !== 2'b01) $display("FAIL rd_gnt got=%b exp=01", bus_if.host_gnt_o);
    else n_pass++;
    n_checks++;
    if (bus_if.device_req_o !== 3'b001 || bus_if.device_addr_o[0] !== 32'h0010_0010)
      $display("FAIL rd_dreq got=%b/%h exp=001/00100010", bus_if.device_req_o, bus_if.device_addr_o[0]);
    else n_pass++;
    advance();
    clear_inputs();
    bus_if.device_rvalid_i[0] = 1'b1;
    bus_if.device_rdata_i[0]  = 32'hDEAD_BEEF;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b01 || bus_if.host_rdata_o[0] !== 32'hDEAD_BEEF || bus_if.host_err_o !== 2'b00)
      $display("FAIL rd_rsp got=%b/%h/%b exp=01/deadbeef/00",
               bus_if.host_rvalid_o, bus_if.host_rdata_o[0], bus_if.host_err_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_write();
    clear_inputs();
    bus_if.host_req_i[0]   = 1'b1;
    bus_if.host_addr_i[0]  = 32'h0002_0000;
    bus_if.host_we_i[0]    = 1'b1;
    bus_if.host_be_i[0]    = 4'hF;
    bus_if.host_wdata_i[0] = 32'h41;
    #2;
    n_checks++;
    if (bus_if.device_req_o !== 3'b010 || bus_if.device_we_o[1] !== 1'b1 ||
        bus_if.device_wdata_o[1] !== 32'h41 || bus_if.device_be_o[1] !== 4'hF)
      $display("FAIL wr_fwd got=%b/%b/%h/%h exp=010/1/41/f", bus_if.device_req_o,
               bus_if.device_we_o[1], bus_if.device_wdata_o[1], bus_if.device_be_o[1]);
    else n_pass++;
    advance();
    clear_inputs();
    bus_if.device_rvalid_i[1] = 1'b1;
    bus_if.device_rdata_i[1]  = 32'h0000_0007;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b01 || bus_if.host_err_o !== 2'b00 || bus_if.host_rdata_o[0] !== 32'h7)
      $display("FAIL wr_rsp got=%b/%b/%h exp=01/00/7", bus_if.host_rvalid_o, bus_if.host_err_o,
               bus_if.host_rdata_o[0]);
    else n_pass++;
    advance();
  endtask

  task automatic test_unmapped();
    clear_inputs();
    bus_if.host_req_i[0]  = 1'b1;
    bus_if.host_addr_i[0] = 32'h0004_0000;
    #2;
    n_checks++;
    if (bus_if.host_gnt_o !== 2'b01 || bus_if.device_req_o !== 3'b000)
      $display("FAIL unm_req got=%b/%b exp=01/000", bus_if.host_gnt_o, bus_if.device_req_o);
    else n_pass++;
    advance();
    clear_inputs();
    bus_if.device_rvalid_i = '1;
    bus_if.device_rdata_i  = {ND{32'h5555_5555}};
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b01 || bus_if.host_err_o !== 2'b01 || bus_if.host_rdata_o[0] !== 32'h0)
      $display("FAIL unm_rsp got=%b/%b/%h exp=01/01/0", bus_if.host_rvalid_o, bus_if.host_err_o,
               bus_if.host_rdata_o[0]);
    else n_pass++;
    advance();
  endtask

  task automatic test_two_hosts();
    clear_inputs();
    bus_if.host_req_i     = 2'b11;
    bus_if.host_addr_i[0] = 32'h0010_0000;
    bus_if.host_addr_i[1] = 32'h0003_0008;
    #2;
    n_checks++;
    if (bus_if.host_gnt_o !== 2'b01 || bus_if.device_req_o !== 3'b001)
      $display("FAIL two_first got=%b/%b exp=01/001", bus_if.host_gnt_o, bus_if.device_req_o);
    else n_pass++;
    advance();
    bus_if.host_req_i         = 2'b10;
    bus_if.device_rvalid_i[0] = 1'b1;
    bus_if.device_rdata_i[0]  = 32'h1111_1111;
    #2;
    n_checks++;
    if (bus_if.host_gnt_o !== 2'b10 || bus_if.device_req_o !== 3'b100 || bus_if.device_addr_o[2] !== 32'h0003_0008)
      $display("FAIL two_second got=%b/%b/%h exp=10/100/00030008", bus_if.host_gnt_o, bus_if.device_req_o,
               bus_if.device_addr_o[2]);
    else n_pass++;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b01 || bus_if.host_rdata_o[0] !== 32'h1111_1111 || bus_if.host_rdata_o[1] !== 32'h0)
      $display("FAIL two_rsp0 got=%b/%h/%h exp=01/11111111/0", bus_if.host_rvalid_o,
               bus_if.host_rdata_o[0], bus_if.host_rdata_o[1]);
    else n_pass++;
    advance();
    clear_inputs();
    bus_if.device_rvalid_i[2] = 1'b1;
    bus_if.device_rdata_i[2]  = 32'h2222_2222;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b10 || bus_if.host_rdata_o[1] !== 32'h2222_2222 || bus_if.host_rdata_o[0] !== 32'h0)
      $display("FAIL two_rsp1 got=%b/%h/%h exp=10/22222222/0", bus_if.host_rvalid_o,
               bus_if.host_rdata_o[1], bus_if.host_rdata_o[0]);
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus_if.host_req_i[0]  = 1'b1;
    bus_if.host_addr_i[0] = 32'h0010_0000;
    #2;
    n_checks++;
    if (bus_if.device_req_o !== 3'b001) $display("FAIL b2b_req1 got=%b exp=001", bus_if.device_req_o);
    else n_pass++;
    advance();
    bus_if.host_addr_i[0]     = 32'h0003_0004;
    bus_if.device_rvalid_i[0] = 1'b1;
    bus_if.device_rdata_i[0]  = 32'h1234_5678;
    #2;
    n_checks++;
    if (bus_if.device_req_o !== 3'b100 || bus_if.host_rvalid_o !== 2'b01 ||
        bus_if.host_rdata_o[0] !== 32'h1234_5678 || bus_if.host_err_o !== 2'b00)
      $display("FAIL b2b_rsp1 got=%b/%b/%h/%b exp=100/01/12345678/00", bus_if.device_req_o,
               bus_if.host_rvalid_o, bus_if.host_rdata_o[0], bus_if.host_err_o);
    else n_pass++;
    advance();
    clear_inputs();
    bus_if.device_rvalid_i   = 3'b101;
    bus_if.device_rdata_i[0] = 32'hFFFF_FFFF;
    bus_if.device_rdata_i[2] = 32'h9ABC_DEF0;
    bus_if.device_err_i[2]   = 1'b1;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b01 || bus_if.host_err_o !== 2'b01 || bus_if.host_rdata_o[0] !== 32'h9ABC_DEF0)
      $display("FAIL b2b_rsp2 got=%b/%b/%h exp=01/01/9abcdef0", bus_if.host_rvalid_o,
               bus_if.host_err_o, bus_if.host_rdata_o[0]);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus_if.host_req_i[0]  = 1'b1;
    bus_if.host_addr_i[0] = 32'h0010_0000;
    #2;
    n_checks++;
    if (bus_if.host_gnt_o !== 2'b01) $display("FAIL rmid_gnt got=%b exp=01", bus_if.host_gnt_o);
    else n_pass++;
    advance();
    clear_inputs();
    rst = 1'b1;
    bus_if.device_rvalid_i[0] = 1'b1;
    bus_if.device_rdata_i[0]  = 32'h77;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b00 || bus_if.host_rdata_o !== '0)
      $display("FAIL rmid_drop got=%b/%h exp=00/0", bus_if.host_rvalid_o, bus_if.host_rdata_o);
    else n_pass++;
    advance();
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus_if.host_rvalid_o !== 2'b00 || bus_if.host_err_o !== 2'b00)
      $display("FAIL rmid_spurious got=%b/%b exp=00/00", bus_if.host_rvalid_o, bus_if.host_err_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < NH; h++) begin
        bus_if.host_req_i[h] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: bus_if.host_addr_i[h] = 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
          1: bus_if.host_addr_i[h] = 32'h0002_0000 | AW'($urandom_range(0, 1023));
          2: bus_if.host_addr_i[h] = 32'h0003_0000 | AW'($urandom_range(0, 1023));
          default: bus_if.host_addr_i[h] = $urandom;
        endcase
        bus_if.host_we_i[h]    = $urandom_range(0, 1) != 0;
        bus_if.host_be_i[h]    = 4'($urandom);
        bus_if.host_wdata_i[h] = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
        bus_if.device_rvalid_i[d] = $urandom_range(0, 1) != 0;
        bus_if.device_rdata_i[d]  = $urandom;
        bus_if.device_err_i[d]    = $urandom_range(0, 1) != 0;
      end
      if (m_valid != 0 && m_dev >= 0) bus_if.device_rvalid_i[m_dev] = 1'b1;
      model_expect();
      #2;
      n_checks++;
      if (bus_if.host_gnt_o !== e_gnt) $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus_if.host_gnt_o, e_gnt);
      else n_pass++;
      n_checks++;
      if (bus_if.device_req_o !== e_dreq) $display("FAIL rnd_dreq c=%0d got=%b exp=%b", c, bus_if.device_req_o, e_dreq);
      else n_pass++;
      n_checks++;
      if (bus_if.host_rvalid_o !== e_rvalid || bus_if.host_err_o !== e_err || bus_if.host_rdata_o !== e_rdata)
        $display("FAIL rnd_rsp c=%0d got=%b/%b/%h exp=%b/%b/%h", c, bus_if.host_rvalid_o, bus_if.host_err_o,
                 bus_if.host_rdata_o, e_rvalid, e_err, e_rdata);
      else n_pass++;
      if (e_win >= 0) begin
        for (int d = 0; d < ND; d++) begin
          n_checks++;
          if (bus_if.device_addr_o[d] !== bus_if.host_addr_i[e_win] || bus_if.device_we_o[d] !== bus_if.host_we_i[e_win] ||
              bus_if.device_be_o[d] !== bus_if.host_be_i[e_win] || bus_if.device_wdata_o[d] !== bus_if.host_wdata_i[e_win])
            $display("FAIL rnd_fwd c=%0d d=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", c, d, bus_if.device_addr_o[d],
                     bus_if.device_we_o[d], bus_if.device_be_o[d], bus_if.device_wdata_o[d],
                     bus_if.host_addr_i[e_win], bus_if.host_we_i[e_win], bus_if.host_be_i[e_win],
                     bus_if.host_wdata_i[e_win]);
          else n_pass++;
        end
      end
      advance();
    end
  endtask

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;
    for (int d = 0; d < ND; d++) begin
      bus_if.cfg_device_addr_base[d] = cfg_base[d];
      bus_if.cfg_device_addr_mask[d] = cfg_mask[d];
    end
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_two_hosts();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Single-outstanding, request/grant/rvalid memory interconnect.
- Connects NrHosts initiators (e.g. core data port) to NrDevices targets (RAM, simulator control, timer).
- Address decode uses per-device base/mask configuration inputs.
- Fixed-priority host arbitration; read data and error are routed back one cycle after the granted request.

Parameters:
NrDevices, 1, number of target devices (>=1)
NrHosts, 1, number of initiators (>=1)
DataWidth, 32, data bus width in bits
AddressWidth, 32, address width in bits

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
host_req_i  in  [NrHosts] x 1  host request
host_gnt_o  out  [NrHosts] x 1  host grant
host_addr_i  in  [NrHosts] x AddressWidth  byte address
host_we_i  in  [NrHosts] x 1  write enable
host_be_i  in  [NrHosts] x DataWidth/8  byte enables
host_wdata_i  in  [NrHosts] x DataWidth  write data
host_rvalid_o  out  [NrHosts] x 1  response valid
host_rdata_o  out  [NrHosts] x DataWidth  read data
host_err_o  out  [NrHosts] x 1  response error
device_req_o  out  [NrDevices] x 1  device request
device_addr_o  out  [NrDevices] x AddressWidth  forwarded address
device_we_o  out  [NrDevices] x 1  forwarded write enable
device_be_o  out  [NrDevices] x DataWidth/8  forwarded byte enables
device_wdata_o  out  [NrDevices] x DataWidth  forwarded write data
device_rvalid_i  in  [NrDevices] x 1  device response valid
device_rdata_i  in  [NrDevices] x DataWidth  device read data
device_err_i  in  [NrDevices] x 1  device error
cfg_device_addr_base  in  [NrDevices] x AddressWidth  device base address
cfg_device_addr_mask  in  [NrDevices] x AddressWidth  device address mask

Behaviour:
- Arbitration (combinational): lowest-index host with host_req_i=1 wins. Only the winner sees host_gnt_o=1, same cycle as its request. All other hosts see gnt=0 and must hold their request.
- Decode (combinational) on winner address: device d hits when (addr & mask[d]) == (base[d] & mask[d]). Lowest matching index wins.
- Forwarding: the hit device gets device_req_o=1 plus the winner's addr/we/be/wdata. All other device_req_o=0.
- Non-selected device addr/we/be/wdata outputs also carry the winner's fields; only req qualifies them.
- Every granted request is accepted that cycle (no device back-pressure). Devices must respond with rvalid exactly one cycle after req.
- Response registers (async reset): rsp_valid, rsp_host, rsp_dev, rsp_unmapped. Captured on each grant, cleared to 0 when there is no grant.
- Response routing, cycle after grant: host_rvalid_o[rsp_host] = device_rvalid_i[rsp_dev], with rdata/err from the same device. Other hosts get rvalid=0, rdata=0, err=0.
- Unmapped address: still granted, no device_req_o. The next cycle drives host_rvalid_o=1, host_err_o=1, host_rdata_o=0 to that host.
- Writes produce an rvalid response like reads; rdata is whatever the device returns.
- Back-to-back grants on consecutive cycles are supported: request N+1 issues while response N returns.
- Device rvalid with no recorded outstanding request is ignored.
- Reset: response registers cleared, so host_rvalid_o=0, host_err_o=0, host_rdata_o=0 for all hosts.
- Request-side outputs are combinational and follow inputs during reset. An in-flight response is discarded on reset.
- No req-free-cycle requirement. No combinational path from device_rvalid_i to any device_* output.

Test Plan:
- Config Ram base 0x100000 / mask 0xFFF00000, SimCtrl 0x20000 / 0xFFFFFC00, Timer 0x30000 / 0xFFFFFC00.
  - Host0 reads 0x100010 -> gnt same cycle, device_req_o[Ram]=1, addr 0x100010.
  - Ram returns rvalid with rdata 0xDEADBEEF next cycle -> host_rvalid_o[0]=1, rdata 0xDEADBEEF, err 0.
- Host0 writes 0x20000, wdata 0x41, be 0xF -> device_req_o[SimCtrl]=1, we=1, wdata 0x41; response routed next cycle.
- Host0 reads 0x40000 (unmapped) -> gnt=1, all device_req_o=0; next cycle rvalid=1, err=1, rdata=0.
- NrHosts=2, both request simultaneously -> host0 granted, host1 gnt=0. Next cycle host1 granted; responses arrive on the correct hosts in order.
- Back-to-back reads 0x100000 then 0x30004 on consecutive cycles -> response 1 from Ram, then response 2 from Timer.
  - Timer err_i=1 on the second response -> host_err_o=1.
- Assert rst_i mid-transaction (cycle after grant) -> host_rvalid_o drops to 0 immediately. After release, no spurious response.
